// File: rtl/pe_os_drain_if.sv
// rtl/pe_os_drain_if.sv - operand, accumulate and drain signal bundle for one PE
interface pe_os_drain_if #(
  parameter int WIDTH = 8,
  parameter int ACC   = 32
);
  logic             valid_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             clear;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             valid_out;
  logic [ACC-1:0]   acc_out;
  logic             ovf;
  logic             drain_capture;
  logic             drain_shift;
  logic [ACC-1:0]   drain_in;
  logic             drain_valid_in;
  logic [ACC-1:0]   drain_out;
  logic             drain_valid_out;

  modport slave (
    input  valid_in, a_in, b_in, clear, drain_capture, drain_shift, drain_in, drain_valid_in,
    output a_out, b_out, valid_out, acc_out, ovf, drain_out, drain_valid_out
  );

  modport master (
    output valid_in, a_in, b_in, clear, drain_capture, drain_shift, drain_in, drain_valid_in,
    input  a_out, b_out, valid_out, acc_out, ovf, drain_out, drain_valid_out
  );
endinterface

// File: rtl/pe_os_drain.sv
// rtl/pe_os_drain.sv - output-stationary PE with optional multiplier stage, saturation and drain chain
module pe_os_drain #(
  parameter int WIDTH     = 8,
  parameter int ACC       = 32,
  parameter int MUL_STAGE = 0,
  parameter int SAT       = 0
) (
  input logic          clk,
  input logic          rst,
  pe_os_drain_if.slave pe
);
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic [ACC-1:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC-1:0]   drain_q, drain_d;
  logic             drain_valid_q, drain_valid_d;

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod_w;
  logic [ACC-1:0]            prod_ext;
  logic [ACC-1:0]            st_p;
  logic                      st_v, st_c;
  logic [ACC:0]              sum_w;
  logic                      sum_ovf;
  logic [ACC-1:0]            sat_val;

  assign a_ext    = (2*WIDTH)'($signed(pe.a_in));
  assign b_ext    = (2*WIDTH)'($signed(pe.b_in));
  assign prod_w   = a_ext * b_ext;
  assign prod_ext = ACC'(prod_w);

  // The clear tag travels with its product so a restart lines up with the first new term.
  if (MUL_STAGE != 0) begin : g_mul_pipe
    logic [ACC-1:0] p_q;
    logic           pv_q, pc_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        p_q  <= '0;
        pv_q <= 1'b0;
        pc_q <= 1'b0;
      end else begin
        p_q  <= prod_ext;
        pv_q <= pe.valid_in;
        pc_q <= pe.clear;
      end
    end
    assign st_p = p_q;
    assign st_v = pv_q;
    assign st_c = pc_q;
  end else begin : g_mul_comb
    assign st_p = prod_ext;
    assign st_v = pe.valid_in;
    assign st_c = pe.clear;
  end

  // One extra bit makes overflow visible as a disagreement of the top two sum bits.
  assign sum_w   = {acc_q[ACC-1], acc_q} + {st_p[ACC-1], st_p};
  assign sum_ovf = sum_w[ACC] ^ sum_w[ACC-1];
  assign sat_val = sum_w[ACC] ? {1'b1, {(ACC-1){1'b0}}} : {1'b0, {(ACC-1){1'b1}}};

  always_comb begin
    valid_d = pe.valid_in;
    a_d     = a_q;
    b_d     = b_q;
    if (pe.valid_in) begin
      a_d = pe.a_in;
      b_d = pe.b_in;
    end

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (st_c) begin
      acc_d = st_v ? st_p : '0;
      ovf_d = 1'b0;
    end else if (st_v) begin
      acc_d = (SAT != 0 && sum_ovf) ? sat_val : sum_w[ACC-1:0];
      if (sum_ovf) begin
        ovf_d = 1'b1;
      end
    end

    // Capture takes the pre-update accumulator, so draining can overlap accumulation.
    drain_d       = drain_q;
    drain_valid_d = drain_valid_q;
    if (pe.drain_capture) begin
      drain_d       = acc_q;
      drain_valid_d = 1'b1;
    end else if (pe.drain_shift) begin
      drain_d       = pe.drain_in;
      drain_valid_d = pe.drain_valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      valid_q       <= 1'b0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      drain_q       <= '0;
      drain_valid_q <= 1'b0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      valid_q       <= valid_d;
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      drain_q       <= drain_d;
      drain_valid_q <= drain_valid_d;
    end
  end

  assign pe.a_out           = a_q;
  assign pe.b_out           = b_q;
  assign pe.valid_out       = valid_q;
  assign pe.acc_out         = acc_q;
  assign pe.ovf             = ovf_q;
  assign pe.drain_out       = drain_q;
  assign pe.drain_valid_out = drain_valid_q;
endmodule

// File: doc/pe_os_drain.md
Name: pe_os_drain

Overview:
- Parametrised output-stationary processing element for the tiny-SA systolic array; successor to the basic `pe`.
- Forwards A (west→east) and B (north→south) operands with valid tags and accumulates signed products locally.
- Adds optional multiplier pipelining, a clear/restart path, saturating or wrapping arithmetic with a sticky overflow flag, and a drain shift chain so an array column can unload its results serially.

Parameters:
- WIDTH, 8: operand width in bits, signed two's complement.
- ACC, 32: accumulator width in bits; must be ≥ 2*WIDTH.
- MUL_STAGE, 0: 0 = product feeds the accumulator in the same cycle; 1 = product is registered first (+1 cycle of accumulate latency).
- SAT, 0: 0 = accumulator wraps modulo 2^ACC; 1 = accumulator clamps to the signed range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  a_in/b_in carry a valid operand pair this cycle.
- a_in  in  WIDTH  signed operand A from the west neighbour.
- b_in  in  WIDTH  signed operand B from the north neighbour.
- clear  in  1  restart accumulation (see Behaviour).
- a_out  out  WIDTH  registered A to the east neighbour.
- b_out  out  WIDTH  registered B to the south neighbour.
- valid_out  out  1  registered valid_in.
- acc_out  out  ACC  accumulator value.
- ovf  out  1  sticky overflow flag.
- drain_capture  in  1  load acc_out into the drain register.
- drain_shift  in  1  shift the drain chain by one PE.
- drain_in  in  ACC  drain data from the upstream PE.
- drain_valid_in  in  1  drain valid from the upstream PE.
- drain_out  out  ACC  drain register to the downstream PE.
- drain_valid_out  out  1  drain register holds data.

Behaviour:
Reset:
- With rst=1 at a clock edge, every register goes to 0: a_out, b_out, valid_out, acc_out, ovf, drain_out, drain_valid_out, and the product pipeline (data, valid, clear tag).
- rst has priority over all other inputs. Reset mid-operation discards in-flight products.

Forwarding:
- valid_out <= valid_in every cycle.
- a_out <= a_in and b_out <= b_in only when valid_in=1; otherwise they hold.
- Latency 1, independent of MUL_STAGE.

Product:
- p = a_in * b_in, full signed 2*WIDTH product, sign-extended to ACC.
- MUL_STAGE=0: p, valid_in and clear go directly to the accumulate stage.
- MUL_STAGE=1: p, valid_in and clear are registered together and reach the accumulate stage one cycle later. A clear is always pipelined with the product it accompanies.

Accumulate stage (v = stage valid, c = stage clear), in priority order:
- c=1, v=1: acc <= p; ovf <= 0.
- c=1, v=0: acc <= 0; ovf <= 0.
- c=0, v=1: acc <= acc + p, evaluated at ACC+1 bits.
  - If the sum is outside [-2^(ACC-1), 2^(ACC-1)-1], set ovf <= 1 (sticky).
  - SAT=1: clamp to the nearest bound.
  - SAT=0: keep the low ACC bits (wrap).
- c=0, v=0: hold.

Drain:
- drain_capture=1: drain_out <= acc_out value before this edge's accumulate update; drain_valid_out <= 1.
- Otherwise, drain_shift=1: drain_out <= drain_in; drain_valid_out <= drain_valid_in.
- Neither asserted: hold.
- If both are asserted in the same cycle, capture wins.
- Drain operations never modify acc_out or ovf, so accumulation may continue during drain.

Test Plan:
- MUL_STAGE=0, after reset, a_in=3, b_in=4, valid_in=1 for 4 cycles -> acc_out 12, 24, 36, 48 on successive edges; a_out=3, b_out=4, valid_out=1 one cycle after the first valid; then valid_in=0 -> acc_out holds 48 and a_out/b_out hold.
- MUL_STAGE=1, same stimulus -> acc_out first shows 12 two edges after the first valid and ends at 48; a_out/b_out latency is still 1.
- ACC=16, SAT=1, a=127, b=127 for 3 valid cycles -> acc_out 16129, 32258, then 32767 with ovf=1; clear with valid_in=0 -> acc_out=0, ovf=0.
- ACC=16, SAT=0, same stimulus -> third value is -17149 with ovf=1; clear together with a=-2, b=5, valid_in=1 -> acc_out=-10, ovf=0.
- Two-PE drain chain holding 48 (PE0) and -10 (PE1):
  - drain_capture on both -> drain_out 48 / -10, drain_valid_out=1.
  - One drain_shift with PE0 drain_in=0, drain_valid_in=0 -> PE1 drain_out=48, PE0 drain_valid_out=0.
  - capture and shift asserted together -> capture wins.
- rst=1 mid-accumulation with MUL_STAGE=1 and a product in flight -> next edge: all outputs 0; no stale product lands in the cycle after rst drops.
